// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard scoreboard bundle: ID-stage operand info, writeback completion and
// branch resolution going in; pipeline enables, flush controls and the
// scoreboard debug vector coming out.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles / flush_events
// performance counter outputs.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [REG_ADDR_W-1:0] rd_id;
  logic                  long_op_id;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  branch_taken;

  logic                  PCWrite;
  logic                  IF_ID_Write;
  logic                  Control_flush;
  logic                  if_id_flush;
  logic [NUM_REGS-1:0]   pending;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           flush_events;

  // Pipeline side: drives operands and events, observes the controls.
  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, long_op_id,
           wb_valid, wb_rd, branch_taken,
    input  PCWrite, IF_ID_Write, Control_flush, if_id_flush, pending,
           stall_cycles, flush_events
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, long_op_id,
           wb_valid, wb_rd, branch_taken,
    output PCWrite, IF_ID_Write, Control_flush, if_id_flush, pending,
           stall_cycles, flush_events
  );
`else
  // Pipeline side: drives operands and events, observes the controls.
  modport master (
    output id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, long_op_id,
           wb_valid, wb_rd, branch_taken,
    input  PCWrite, IF_ID_Write, Control_flush, if_id_flush, pending
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, long_op_id,
           wb_valid, wb_rd, branch_taken,
    output PCWrite, IF_ID_Write, Control_flush, if_id_flush, pending
  );
`endif
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the in-order pipeline. A per-register pending-write
// scoreboard tracks outstanding long-latency producers (loads, multi-cycle
// ALU ops); an ID instruction reading a pending register is held with a
// bubble until the producer's writeback clears the bit. A small RUN/FLUSH
// FSM keeps IF/ID flushed for FETCH_LAT cycles after a taken branch.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles and
// flush_events counters.
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int FETCH_LAT  = 1,
  parameter int WB_BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard_scoreboard_unit_if.slave  hz
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int                CNT_W        = 4;
  localparam logic [CNT_W-1:0]  FLUSH_RELOAD = CNT_W'(FETCH_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam bit                MULTI_FLUSH  = (FETCH_LAT > 1);
  localparam bit                BYPASS_EN    = (WB_BYPASS != 0);

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic [CNT_W-1:0]    flush_cnt;
  logic [CNT_W-1:0]    flush_cnt_nxt;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;

  logic in_run;
  logic in_flush;
  logic hit_rs1;
  logic hit_rs2;
  logic stall;
  logic issue;
  logic wb_clear;

  // A source is blocked when it reads a pending register, unless that
  // register's producer is writing back this very cycle and the result is
  // forwarded into ID.
  function automatic logic src_hit(
    input logic                  used,
    input logic [REG_ADDR_W-1:0] src,
    input logic [NUM_REGS-1:0]   pend,
    input logic                  wb_v,
    input logic [REG_ADDR_W-1:0] wb_r
  );
    logic bypassed;
    bypassed = BYPASS_EN && wb_v && (wb_r == src);
    return used && (src != '0) && pend[src] && !bypassed;
  endfunction

  // Hazard detection and issue qualification for the instruction in ID.
  always_comb begin
    in_run   = (state == ST_RUN);
    in_flush = (state == ST_FLUSH);
    hit_rs1  = src_hit(hz.rs1_used, hz.rs1_id, pending_q, hz.wb_valid, hz.wb_rd);
    hit_rs2  = src_hit(hz.rs2_used, hz.rs2_id, pending_q, hz.wb_valid, hz.wb_rd);
    // A taken branch discards the ID instruction, so it never stalls.
    stall    = rst_n && hz.id_valid && (hit_rs1 || hit_rs2) && in_run &&
               !hz.branch_taken;
    issue    = hz.id_valid && !stall && in_run && !hz.branch_taken &&
               hz.long_op_id && (hz.rd_id != '0);
    wb_clear = hz.wb_valid && (hz.wb_rd != '0);
  end

  // Pipeline enables and flush controls; forced benign while in reset.
  always_comb begin
    hz.PCWrite       = !stall;
    hz.IF_ID_Write   = !stall;
    hz.Control_flush = rst_n && (stall || hz.branch_taken || in_flush);
    hz.if_id_flush   = rst_n && (hz.branch_taken || in_flush);
  end

  assign hz.pending = pending_q;

  // Scoreboard next state: clear on writeback, then set on issue so a new
  // producer of the same register wins over the old one's completion.
  always_comb begin
    pending_nxt = pending_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (wb_clear && (int'(hz.wb_rd) == r)) pending_nxt[r] = 1'b0;
      if (issue && (int'(hz.rd_id) == r))    pending_nxt[r] = 1'b1;
    end
  end

  // Flush sequencer: a branch (re)loads the remaining-flush count; FLUSH
  // returns to RUN once the last counted cycle has been spent.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_RUN: begin
        if (hz.branch_taken && MULTI_FLUSH) begin
          state_nxt     = ST_FLUSH;
          flush_cnt_nxt = FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (hz.branch_taken) begin
          flush_cnt_nxt = FLUSH_RELOAD;
        end else if (flush_cnt <= CNT_ONE) begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt     = ST_RUN;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  // State registers; reset discards every outstanding producer and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      pending_q <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pending_q <= pending_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_events_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters: stalled cycles and taken-branch cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall)           stall_cycles_q <= sat_inc(stall_cycles_q);
      if (hz.branch_taken) flush_events_q <= sat_inc(flush_events_q);
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`endif

endmodule
